// File: rtl/usb_proto_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_proto_ctrl
// Brief    : USB 1.1 device transaction sequencer: token decode, reply select,
//            data_buffer clear and bus-turnaround timeout.
//            Optional macro: USB_CTRL_DATA_TOGGLE_EN (DATA0/DATA1 tracking).
// Revision : 1.0  initial release
// ============================================================================
module usb_proto_ctrl #(
   parameter int RESP_TIMEOUT = 200,
   parameter int MAX_PKT      = 64
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] rx_packet,
   input  logic       rx_data_ready,
   input  logic       rx_error,
   input  logic       rx_transfer_active,
   input  logic [6:0] buffer_occupancy,
   input  logic       host_tx_ready,
   input  logic       host_stall,
   input  logic       tx_done,
   output logic [2:0] tx_packet,
   output logic       clear,
   output logic       rx_done,
   output logic       tx_ack,
   output logic       xfer_err,
   output logic       busy
);
   localparam logic [1:0] c_st_idle      = 2'd0;
   localparam logic [1:0] c_st_wait_data = 2'd1;
   localparam logic [1:0] c_st_send_resp = 2'd2;
   localparam logic [1:0] c_st_wait_ack  = 2'd3;

   localparam logic [2:0] c_rx_out   = 3'd1;
   localparam logic [2:0] c_rx_in    = 3'd2;
   localparam logic [2:0] c_rx_data0 = 3'd3;
   localparam logic [2:0] c_rx_ack   = 3'd4;
   localparam logic [2:0] c_rx_data1 = 3'd7;

   localparam logic [2:0] c_tx_none  = 3'd0;
   localparam logic [2:0] c_tx_data0 = 3'd1;
   localparam logic [2:0] c_tx_ack   = 3'd2;
   localparam logic [2:0] c_tx_nak   = 3'd3;
   localparam logic [2:0] c_tx_stall = 3'd4;
   localparam logic [2:0] c_tx_data1 = 3'd5;

   localparam logic [7:0] c_timeout = 8'(RESP_TIMEOUT);
   localparam logic [6:0] c_max_pkt = 7'(MAX_PKT);

   logic [1:0] r_state, w_state_nxt;
   logic [7:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [2:0] r_tx_packet, w_tx_packet_nxt;
   logic       r_clear, w_clear_nxt;
   logic       r_rx_done, w_rx_done_nxt;
   logic       r_tx_ack, w_tx_ack_nxt;
   logic       r_xfer_err, w_xfer_err_nxt;
   logic       r_busy;
   logic       r_from_out, w_from_out_nxt;

   logic       w_tok_valid, w_is_data, w_overflow, w_timeout, w_tx_is_data;
   logic       w_out_accept, w_ack_done, w_in_acked, w_tog_bad;
   logic [2:0] w_in_data_code;

   assign w_tok_valid  = rx_data_ready && !rx_error;
   assign w_is_data    = (rx_packet == c_rx_data0) || (rx_packet == c_rx_data1);
   assign w_overflow   = buffer_occupancy > c_max_pkt;
   assign w_cnt_inc    = rx_transfer_active ? r_cnt : r_cnt + 8'd1;
   // Fires on the cycle the idle-bus count would reach RESP_TIMEOUT.
   assign w_timeout    = !rx_transfer_active && (r_cnt == c_timeout - 8'd1);
   assign w_tx_is_data = (r_tx_packet == c_tx_data0) || (r_tx_packet == c_tx_data1);

   assign w_out_accept = (r_state == c_st_wait_data) && w_tok_valid && w_is_data && !w_overflow;
   assign w_ack_done   = (r_state == c_st_send_resp) && tx_done && (r_tx_packet == c_tx_ack);
   assign w_in_acked   = (r_state == c_st_wait_ack) && w_tok_valid && (rx_packet == c_rx_ack);

`ifdef USB_CTRL_DATA_TOGGLE_EN
   logic r_in_tog, r_out_tog, r_tog_bad;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_in_tog  <= 1'b0;
         r_out_tog <= 1'b0;
         r_tog_bad <= 1'b0;
      end else begin
         if (w_in_acked)
            r_in_tog <= ~r_in_tog;
         if (w_out_accept)
            r_tog_bad <= (rx_packet == c_rx_data1) != r_out_tog;
         // A repeated (mismatched) packet is ACKed but must not advance the sequence.
         if (w_ack_done && !r_tog_bad)
            r_out_tog <= ~r_out_tog;
      end
   end

   assign w_in_data_code = r_in_tog ? c_tx_data1 : c_tx_data0;
   assign w_tog_bad      = r_tog_bad;
`else
   assign w_in_data_code = c_tx_data0;
   assign w_tog_bad      = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= c_st_idle;
         r_cnt       <= 8'd0;
         r_tx_packet <= c_tx_none;
         r_clear     <= 1'b0;
         r_rx_done   <= 1'b0;
         r_tx_ack    <= 1'b0;
         r_xfer_err  <= 1'b0;
         r_busy      <= 1'b0;
         r_from_out  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tx_packet <= w_tx_packet_nxt;
         r_clear     <= w_clear_nxt;
         r_rx_done   <= w_rx_done_nxt;
         r_tx_ack    <= w_tx_ack_nxt;
         r_xfer_err  <= w_xfer_err_nxt;
         r_busy      <= (w_state_nxt != c_st_idle);
         r_from_out  <= w_from_out_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_tok_valid && (rx_packet == c_rx_out))
               w_state_nxt = c_st_wait_data;
            else if (w_tok_valid && (rx_packet == c_rx_in))
               w_state_nxt = c_st_send_resp;
         end
         c_st_wait_data: begin
            if (rx_error)
               w_state_nxt = c_st_idle;
            else if (rx_data_ready && w_is_data)
               w_state_nxt = w_overflow ? c_st_idle : c_st_send_resp;
            else if (w_timeout)
               w_state_nxt = c_st_idle;
         end
         c_st_send_resp: begin
            if (tx_done)
               w_state_nxt = w_tx_is_data ? c_st_wait_ack : c_st_idle;
         end
         c_st_wait_ack: begin
            if (rx_error || rx_data_ready || w_timeout)
               w_state_nxt = c_st_idle;
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      w_tx_packet_nxt = r_tx_packet;
      w_clear_nxt     = 1'b0;
      w_rx_done_nxt   = 1'b0;
      w_tx_ack_nxt    = 1'b0;
      w_xfer_err_nxt  = r_xfer_err;
      w_from_out_nxt  = r_from_out;
      w_cnt_nxt       = r_cnt;
      case (r_state)
         c_st_idle: begin
            if (rx_error) begin
               w_xfer_err_nxt = 1'b1;
            end else if (rx_data_ready && (rx_packet == c_rx_out)) begin
               w_cnt_nxt      = 8'd0;
               w_xfer_err_nxt = 1'b0;
               w_from_out_nxt = 1'b1;
            end else if (rx_data_ready && (rx_packet == c_rx_in)) begin
               w_xfer_err_nxt = 1'b0;
               w_from_out_nxt = 1'b0;
               if (host_stall)
                  w_tx_packet_nxt = c_tx_stall;
               else if (host_tx_ready)
                  w_tx_packet_nxt = w_in_data_code;
               else
                  w_tx_packet_nxt = c_tx_nak;
            end
         end
         c_st_wait_data: begin
            w_cnt_nxt = w_cnt_inc;
            if (rx_error || (!(rx_data_ready && w_is_data) && w_timeout)) begin
               w_clear_nxt    = 1'b1;
               w_xfer_err_nxt = 1'b1;
            end else if (rx_data_ready && w_is_data) begin
               if (w_overflow) begin
                  w_clear_nxt    = 1'b1;
                  w_xfer_err_nxt = 1'b1;
               end else begin
                  w_tx_packet_nxt = host_stall ? c_tx_stall : c_tx_ack;
               end
            end
         end
         c_st_send_resp: begin
            if (tx_done) begin
               w_tx_packet_nxt = c_tx_none;
               if (r_tx_packet == c_tx_ack) begin
                  w_rx_done_nxt = !w_tog_bad;
                  w_clear_nxt   = w_tog_bad;
               end else if (w_tx_is_data) begin
                  w_cnt_nxt = 8'd0;
               end else if ((r_tx_packet == c_tx_stall) && r_from_out) begin
                  w_clear_nxt = 1'b1;
               end
            end
         end
         c_st_wait_ack: begin
            w_cnt_nxt = w_cnt_inc;
            // On failure the buffer is kept so the host can retry the IN.
            if (w_in_acked) begin
               w_tx_ack_nxt = 1'b1;
               w_clear_nxt  = 1'b1;
            end else if (rx_error || rx_data_ready || w_timeout) begin
               w_xfer_err_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign tx_packet = r_tx_packet;
   assign clear     = r_clear;
   assign rx_done   = r_rx_done;
   assign tx_ack    = r_tx_ack;
   assign xfer_err  = r_xfer_err;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_usb_proto_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_proto_ctrl
// Brief    : Self-checking bench for usb_proto_ctrl: vector table, corner-case
//            sequences and random transactions against a transaction model.
// Revision : 1.0  initial release
// ============================================================================
module tb_usb_proto_ctrl;
   localparam logic [2:0] P_OUT = 3'd1, P_IN = 3'd2, P_DATA0 = 3'd3, P_ACK = 3'd4;
   localparam logic [2:0] P_NAK = 3'd5, P_DATA1 = 3'd7;
   localparam logic [2:0] T_NONE = 3'd0, T_DATA0 = 3'd1, T_ACK = 3'd2, T_NAK = 3'd3;
   localparam logic [2:0] T_STALL = 3'd4, T_DATA1 = 3'd5;
`ifdef USB_CTRL_DATA_TOGGLE_EN
   localparam bit TOG_EN = 1'b1;
`else
   localparam bit TOG_EN = 1'b0;
`endif
   localparam logic [2:0] T_SECOND  = TOG_EN ? T_DATA1 : T_DATA0;
   localparam logic       MIS_DONE  = TOG_EN ? 1'b0 : 1'b1;
   localparam logic       MIS_CLR   = TOG_EN ? 1'b1 : 1'b0;

   logic       tb_clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [2:0] rx_packet = 3'd0;
   logic       rx_data_ready = 1'b0, rx_error = 1'b0, rx_transfer_active = 1'b0;
   logic [6:0] buffer_occupancy = 7'd0;
   logic       host_tx_ready = 1'b0, host_stall = 1'b0, tx_done = 1'b0;
   logic [2:0] tx_packet;
   logic       clear, rx_done, tx_ack, xfer_err, busy;

   int n_checks = 0;
   int n_errors = 0;
   logic m_in_tog = 1'b0;
   logic m_out_tog = 1'b0;

   usb_proto_ctrl #(.RESP_TIMEOUT(200), .MAX_PKT(64)) dut (
      .clk(tb_clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
      .rx_error(rx_error), .rx_transfer_active(rx_transfer_active),
      .buffer_occupancy(buffer_occupancy), .host_tx_ready(host_tx_ready),
      .host_stall(host_stall), .tx_done(tx_done), .tx_packet(tx_packet), .clear(clear),
      .rx_done(rx_done), .tx_ack(tx_ack), .xfer_err(xfer_err), .busy(busy)
   );

   always #5 tb_clk = ~tb_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [2:0] tok, dpid;
      logic [6:0] occ;
      logic       stall, ready, derr;
      logic [2:0] hresp;
      logic [2:0] exp_tx;
      logic       clr_now, err_now, exp_done, clr_end, exp_ack, err_end;
   } vec_t;

   function automatic vec_t mk(logic [2:0] tok, logic [2:0] dpid, logic [6:0] occ,
                               logic stall, logic ready, logic derr, logic [2:0] hresp,
                               logic [2:0] exp_tx, logic clr_now, logic err_now,
                               logic exp_done, logic clr_end, logic exp_ack, logic err_end);
      vec_t v;
      v.tok = tok; v.dpid = dpid; v.occ = occ; v.stall = stall; v.ready = ready;
      v.derr = derr; v.hresp = hresp; v.exp_tx = exp_tx; v.clr_now = clr_now;
      v.err_now = err_now; v.exp_done = exp_done; v.clr_end = clr_end;
      v.exp_ack = exp_ack; v.err_end = err_end;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      rx_data_ready = 1'b0; rx_error = 1'b0; tx_done = 1'b0; rx_packet = 3'd0;
      repeat (3) @(posedge tb_clk);
      #1 n_rst = 1'b1;
      m_in_tog = 1'b0;
      m_out_tog = 1'b0;
      step();
   endtask

   task automatic pulse_rx(input logic [2:0] pid, input logic err);
      rx_packet = pid; rx_data_ready = 1'b1; rx_error = err;
      step();
      rx_packet = 3'd0; rx_data_ready = 1'b0; rx_error = 1'b0;
   endtask

   // Runs one complete transaction and checks it against the expected fields.
   task automatic do_txn(input vec_t v, input int gap);
      host_stall = v.stall; host_tx_ready = v.ready; buffer_occupancy = v.occ;
      pulse_rx(v.tok, 1'b0);
      if (v.tok == P_OUT) begin
         chk("out_busy", {7'd0, busy}, 8'd1);
         chk("out_err_cleared", {7'd0, xfer_err}, 8'd0);
         repeat (gap) step();
         pulse_rx(v.dpid, v.derr);
      end
      chk("reply", {5'd0, tx_packet}, {5'd0, v.exp_tx});
      chk("clear_now", {7'd0, clear}, {7'd0, v.clr_now});
      chk("err_now", {7'd0, xfer_err}, {7'd0, v.err_now});
      if (v.exp_tx != T_NONE) begin
         repeat (gap) step();
         chk("reply_hold", {5'd0, tx_packet}, {5'd0, v.exp_tx});
         tx_done = 1'b1; step(); tx_done = 1'b0;
         chk("tx_drop", {5'd0, tx_packet}, 8'd0);
         chk("rx_done", {7'd0, rx_done}, {7'd0, v.exp_done});
         chk("clear_end", {7'd0, clear}, {7'd0, v.clr_end});
         if (v.exp_tx == T_DATA0 || v.exp_tx == T_DATA1) begin
            chk("wait_ack_busy", {7'd0, busy}, 8'd1);
            repeat (gap) step();
            pulse_rx(v.hresp, 1'b0);
            chk("tx_ack", {7'd0, tx_ack}, {7'd0, v.exp_ack});
            chk("ack_clear", {7'd0, clear}, {7'd0, v.exp_ack});
         end
         chk("err_end", {7'd0, xfer_err}, {7'd0, v.err_end});
      end
      chk("idle_busy", {7'd0, busy}, 8'd0);
      step();
      chk("pulses_low", {5'd0, clear, rx_done, tx_ack}, 8'd0);
   endtask

   // Transaction-level reference: derives outcomes from the protocol rules.
   task automatic model(inout vec_t v);
      v.exp_tx = T_NONE; v.clr_now = 0; v.err_now = 0; v.exp_done = 0;
      v.clr_end = 0; v.exp_ack = 0; v.err_end = 0;
      if (v.tok == P_IN) begin
         if (v.stall) v.exp_tx = T_STALL;
         else if (v.ready) v.exp_tx = (TOG_EN && m_in_tog) ? T_DATA1 : T_DATA0;
         else v.exp_tx = T_NAK;
         if (v.exp_tx == T_DATA0 || v.exp_tx == T_DATA1) begin
            if (v.hresp == P_ACK) begin
               v.exp_ack = 1;
               m_in_tog = ~m_in_tog;
            end else begin
               v.err_end = 1;
            end
         end
      end else if (v.derr || v.occ > 7'd64) begin
         v.clr_now = 1; v.err_now = 1;
      end else if (v.stall) begin
         v.exp_tx = T_STALL; v.clr_end = 1;
      end else begin
         v.exp_tx = T_ACK;
         if (TOG_EN && ((v.dpid == P_DATA1) != m_out_tog)) begin
            v.clr_end = 1;
         end else begin
            v.exp_done = 1;
            m_out_tog = ~m_out_tog;
         end
      end
   endtask

   vec_t tbl[12];
   vec_t rv;
   int   n;

   initial begin
      //            tok    dpid     occ    stl rdy der hresp  exp_tx    cn cr dn ce ak ee
      tbl[0]  = mk(P_OUT, P_DATA0, 7'd8,  0, 0, 0, P_ACK, T_ACK,    0, 0, 1, 0, 0, 0);
      tbl[1]  = mk(P_OUT, P_DATA1, 7'd64, 0, 0, 0, P_ACK, T_ACK,    0, 0, 1, 0, 0, 0);
      tbl[2]  = mk(P_OUT, P_DATA1, 7'd20, 0, 0, 0, P_ACK, T_ACK,    0, 0, MIS_DONE, MIS_CLR, 0, 0);
      tbl[3]  = mk(P_OUT, P_DATA0, 7'd65, 0, 0, 0, P_ACK, T_NONE,   1, 1, 0, 0, 0, 0);
      tbl[4]  = mk(P_OUT, P_DATA0, 7'd10, 1, 0, 0, P_ACK, T_STALL,  0, 0, 0, 1, 0, 0);
      tbl[5]  = mk(P_OUT, P_DATA0, 7'd10, 0, 0, 1, P_ACK, T_NONE,   1, 1, 0, 0, 0, 0);
      tbl[6]  = mk(P_IN,  P_DATA0, 7'd10, 0, 0, 0, P_ACK, T_NAK,    0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(P_IN,  P_DATA0, 7'd10, 1, 1, 0, P_ACK, T_STALL,  0, 0, 0, 0, 0, 0);
      tbl[8]  = mk(P_IN,  P_DATA0, 7'd10, 0, 1, 0, P_ACK, T_DATA0,  0, 0, 0, 0, 1, 0);
      tbl[9]  = mk(P_IN,  P_DATA0, 7'd10, 0, 1, 0, P_NAK, T_SECOND, 0, 0, 0, 0, 0, 1);
      tbl[10] = mk(P_IN,  P_DATA0, 7'd10, 0, 1, 0, P_ACK, T_SECOND, 0, 0, 0, 0, 1, 0);
      tbl[11] = mk(P_OUT, P_DATA0, 7'd0,  0, 0, 0, P_ACK, T_ACK,    0, 0, 1, 0, 0, 0);

      do_reset();
      chk("rst_tx_packet", {5'd0, tx_packet}, 8'd0);
      chk("rst_clear", {7'd0, clear}, 8'd0);
      chk("rst_rx_done", {7'd0, rx_done}, 8'd0);
      chk("rst_tx_ack", {7'd0, tx_ack}, 8'd0);
      chk("rst_xfer_err", {7'd0, xfer_err}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);

      for (int i = 0; i < 12; i++) do_txn(tbl[i], 2);

      // OUT with no data: abort exactly RESP_TIMEOUT cycles after the token.
      host_stall = 0; host_tx_ready = 0;
      pulse_rx(P_OUT, 1'b0);
      n = 0;
      while (clear !== 1'b1 && n < 300) begin step(); n++; end
      chk("out_timeout_cycles", 8'(n), 8'd200);
      chk("out_timeout_err", {7'd0, xfer_err}, 8'd1);
      chk("out_timeout_busy", {7'd0, busy}, 8'd0);
      do_txn(mk(P_IN, P_DATA0, 7'd5, 0, 0, 0, P_ACK, T_NAK, 0, 0, 0, 0, 0, 0), 1);

      // Missing host handshake after DATA: error, buffer kept.
      host_tx_ready = 1;
      pulse_rx(P_IN, 1'b0);
      chk("ack_to_reply", {5'd0, tx_packet}, {5'd0, T_DATA0});
      tx_done = 1; step(); tx_done = 0;
      n = 0;
      while (xfer_err !== 1'b1 && n < 300) begin
         if (clear) chk("ack_to_no_clear", {7'd0, clear}, 8'd0);
         step(); n++;
      end
      chk("ack_timeout_cycles", 8'(n), 8'd200);
      chk("ack_timeout_busy", {7'd0, busy}, 8'd0);

      // rx_error beats rx_data_ready on a token.
      do_txn(mk(P_IN, P_DATA0, 7'd5, 0, 0, 0, P_ACK, T_NAK, 0, 0, 0, 0, 0, 0), 0);
      host_tx_ready = 1;
      pulse_rx(P_IN, 1'b1);
      chk("tok_err_tx", {5'd0, tx_packet}, 8'd0);
      chk("tok_err_busy", {7'd0, busy}, 8'd0);
      chk("tok_err_flag", {7'd0, xfer_err}, 8'd1);

      // Asynchronous reset while a reply is outstanding.
      host_stall = 1;
      pulse_rx(P_IN, 1'b0);
      chk("pre_rst_tx", {5'd0, tx_packet}, {5'd0, T_STALL});
      #1 n_rst = 1'b0;
      #1;
      chk("async_rst_tx", {5'd0, tx_packet}, 8'd0);
      chk("async_rst_busy", {7'd0, busy}, 8'd0);
      chk("async_rst_err", {7'd0, xfer_err}, 8'd0);
      do_reset();

      for (int i = 0; i < 40; i++) begin
         rv.tok   = ($urandom_range(0, 1) == 0) ? P_OUT : P_IN;
         rv.dpid  = ($urandom_range(0, 1) == 0) ? P_DATA0 : P_DATA1;
         rv.occ   = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(65, 127))
                                                 : 7'($urandom_range(0, 64));
         rv.stall = ($urandom_range(0, 3) == 0);
         rv.ready = ($urandom_range(0, 1) == 1);
         rv.derr  = ($urandom_range(0, 7) == 0);
         rv.hresp = ($urandom_range(0, 3) == 0) ? P_NAK : P_ACK;
         rx_transfer_active = 1'b0;
         model(rv);
         do_txn(rv, int'($urandom_range(0, 12)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
